// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, FSM encoding,
// opcode constants and operand extension helpers.
package alu_pkg;

    localparam int OPW = 4;
    localparam int RW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // sel[3]=0 selects signed arithmetic, sel[3]=1 selects bitwise logic
    localparam logic [OPW-1:0] ADD   = 4'h0;
    localparam logic [OPW-1:0] SUB   = 4'h1;
    localparam logic [OPW-1:0] RSUB  = 4'h2;
    localparam logic [OPW-1:0] INC_A = 4'h3;
    localparam logic [OPW-1:0] INC_B = 4'h4;
    localparam logic [OPW-1:0] DEC_A = 4'h5;
    localparam logic [OPW-1:0] DEC_B = 4'h6;
    localparam logic [OPW-1:0] MUL   = 4'h7;
    localparam logic [OPW-1:0] NOT_A = 4'h8;
    localparam logic [OPW-1:0] NOT_B = 4'h9;
    localparam logic [OPW-1:0] AND   = 4'hA;
    localparam logic [OPW-1:0] OR    = 4'hB;
    localparam logic [OPW-1:0] NAND  = 4'hC;
    localparam logic [OPW-1:0] NOR   = 4'hD;
    localparam logic [OPW-1:0] XOR   = 4'hE;
    localparam logic [OPW-1:0] XNOR  = 4'hF;

    function automatic logic [RW-1:0] sext(input logic [OPW-1:0] v);
        return {{(RW-OPW){v[OPW-1]}}, v};
    endfunction

    function automatic logic [RW-1:0] zext(input logic [OPW-1:0] v);
        return {{(RW-OPW){1'b0}}, v};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU producing an 8-bit result; arithmetic is signed and
// sign-extended, logic operates on zero-extended operands.
module alu
    import alu_pkg::*;
(
    input  logic [OPW-1:0] sel,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [RW-1:0]  y
);

    logic [RW-1:0] a_s;
    logic [RW-1:0] b_s;
    logic [RW-1:0] a_z;
    logic [RW-1:0] b_z;

    assign a_s = sext(a);
    assign b_s = sext(b);
    assign a_z = zext(a);
    assign b_z = zext(b);

    // Two's-complement wrap in RW bits gives the signed result directly,
    // including the 4x4 signed product which always fits in 8 bits.
    always_comb begin
        y = '0;
        case (sel)
            ADD:     y = a_s + b_s;
            SUB:     y = a_s - b_s;
            RSUB:    y = b_s - a_s;
            INC_A:   y = a_s + 8'd1;
            INC_B:   y = b_s + 8'd1;
            DEC_A:   y = a_s - 8'd1;
            DEC_B:   y = b_s - 8'd1;
            MUL:     y = a_s * b_s;
            NOT_A:   y = ~a_z;
            NOT_B:   y = ~b_z;
            AND:     y = a_z & b_z;
            OR:      y = a_z | b_z;
            NAND:    y = ~(a_z & b_z);
            NOR:     y = ~(a_z | b_z);
            XOR:     y = a_z ^ b_z;
            XNOR:    y = ~(a_z ^ b_z);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: one operation in flight,
// round-robin or fixed-priority grant, result held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_sel,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_sel,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [RW-1:0]  rsp_data
);

    // state   | meaning
    // IDLE    | waiting for a request; grant is combinational
    // EXEC    | captured operands drive the ALU, result registered
    // RESP    | result held until rsp_ready

    state_t         state_q, state_d;
    logic [OPW-1:0] sel_q, sel_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic           id_q, id_d;
    logic           ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [RW-1:0]  rsp_data_q, rsp_data_d;

    logic           any_valid;
    logic           grant_id;
    logic           grant;
    logic [RW-1:0]  alu_y;

    alu u_alu (
        .sel (sel_q),
        .a   (a_q),
        .b   (b_q),
        .y   (alu_y)
    );

    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ptr_q : ~req0_valid;
    // Gating with rst_n keeps the grant off while reset is held, since IDLE
    // is also the reset state.
    assign grant     = rst_n && (state_q == ST_IDLE) && any_valid;

    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant &&  grant_id;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    sel_d   = grant_id ? req1_sel : req0_sel;
                    a_d     = grant_id ? req1_a   : req0_a;
                    b_d     = grant_id ? req1_b   : req0_b;
                    id_d    = grant_id;
                    ptr_d   = (RR_EN != 0) ? ~grant_id : 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
